nn_output_writeback: RTL

Downstream writeback stage for the neural accelerator's output stream. It accepts 32-bit signed accumulator results in order over a valid/ready handshake and requantizes each one to signed 8-bit using a rounding arithmetic shift with saturation. It packs four results little-endian into one 32-bit word, buffers packed words in a FIFO, and drains them to memory over a byte-strobed write port. It signals completion with a one-cycle `done` pulse and a sticky `interrupt`.

---
 rtl/nn_output_writeback.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_output_writeback.sv
// nn_output_writeback: requantizes signed 32-bit accumulator results to int8, packs four per word
// and drains packed words through a FIFO to a byte-strobed memory port. Build option: NN_WB_RELU_EN.
module nn_output_writeback #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           total_outputs,
    input  logic [4:0]            shift_amt,
    input  logic                  irq_clear,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic [3:0]            mem_strb,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  interrupt,
    output logic [31:0]           words_written
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW    = ADDR_WIDTH + 36;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2, ST_DONE = 2'd3} state_t;

    // Rounding arithmetic shift followed by saturation to the int8 (or ReLU) range.
    function automatic logic [7:0] requant(input logic [31:0] d, input logic [4:0] sh);
        logic signed [33:0] ext;
        logic signed [33:0] rnd;
        logic signed [33:0] shf;
        logic [7:0]         q;
        ext = {{2{d[31]}}, d};
        rnd = (sh != 5'd0) ? (34'sd1 <<< (sh - 5'd1)) : 34'sd0;
        shf = (ext + rnd) >>> sh;
        if (shf > 34'sd127) q = 8'h7F;
`ifdef NN_WB_RELU_EN
        else if (shf < 34'sd0) q = 8'h00;
`else
        else if (shf < -34'sd128) q = 8'h80;
`endif
        else q = shf[7:0];
        return q;
    endfunction

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [31:0]           total_r, elem_cnt_r, word_idx_r, words_written_r;
    logic [4:0]            shift_r;
    logic [31:0]           pack_data_r, merged_data_s;
    logic [3:0]            pack_strb_r, merged_strb_s;
    logic [PW-1:0]         body_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]        body_cnt_r;
    logic                  mem_valid_r, irq_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_data_r;
    logic [3:0]            mem_strb_r;
    logic [PW-1:0]         push_payload_s;
    logic [1:0]            lane_s;
    logic [7:0]            q_s;
    logic start_ok_s, fifo_full_s, in_ready_s, accept_s, last_s, push_s, pop_s;
    logic head_free_s, head_from_body_s, head_from_push_s, body_push_s;

    // Handshake, packing and FIFO steering decisions. The head register counts as one FIFO entry.
    always_comb begin
        start_ok_s    = start && (state_r == ST_IDLE);
        fifo_full_s   = (body_cnt_r + {{PTR_W{1'b0}}, mem_valid_r}) == DEPTH_C;
        in_ready_s    = (state_r == ST_RUN) && !fifo_full_s && (elem_cnt_r < total_r);
        accept_s      = in_valid && in_ready_s;
        last_s        = (elem_cnt_r + 32'd1) == total_r;
        lane_s        = elem_cnt_r[1:0];
        q_s           = requant(in_data, shift_r);
        merged_data_s = pack_data_r;
        merged_strb_s = pack_strb_r;
        merged_data_s[8*lane_s +: 8] = q_s;
        merged_strb_s[lane_s]        = 1'b1;
        push_s         = accept_s && ((lane_s == 2'd3) || last_s);
        push_payload_s = {base_r + ADDR_WIDTH'({word_idx_r, 2'b00}), merged_data_s, merged_strb_s};
        pop_s            = mem_valid_r && mem_ready;
        head_free_s      = !mem_valid_r || pop_s;
        head_from_body_s = head_free_s && (body_cnt_r != '0);
        head_from_push_s = head_free_s && (body_cnt_r == '0) && push_s;
        body_push_s      = push_s && !head_from_push_s;
    end

    // Next-state logic; FLUSH is entered on the edge that accepts the final element.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = (total_outputs == 32'd0) ? ST_DONE : ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if ((accept_s && last_s) || (elem_cnt_r == total_r)) state_s = ST_FLUSH;
                else                                                 state_s = ST_RUN;
            end
            ST_FLUSH: begin
                if ((body_cnt_r == '0) && head_free_s) state_s = ST_DONE;
                else                                   state_s = ST_FLUSH;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_s;
    end

    // Job configuration, element/word counters and the partial-word pack register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_r <= '0; total_r <= 32'd0; shift_r <= 5'd0;
            elem_cnt_r <= 32'd0; word_idx_r <= 32'd0; words_written_r <= 32'd0;
            pack_data_r <= 32'd0; pack_strb_r <= 4'd0;
        end else if (start_ok_s) begin
            base_r     <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            total_r    <= total_outputs;
            shift_r    <= shift_amt;
            elem_cnt_r <= 32'd0; word_idx_r <= 32'd0; words_written_r <= 32'd0;
            pack_data_r <= 32'd0; pack_strb_r <= 4'd0;
        end else begin
            if (accept_s) begin
                elem_cnt_r <= elem_cnt_r + 32'd1;
                if (push_s) begin
                    word_idx_r  <= word_idx_r + 32'd1;
                    pack_data_r <= 32'd0;
                    pack_strb_r <= 4'd0;
                end else begin
                    pack_data_r <= merged_data_s;
                    pack_strb_r <= merged_strb_s;
                end
            end
            if (pop_s) words_written_r <= words_written_r + 32'd1;
        end
    end

    // FIFO body pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0; rd_ptr_r <= '0; body_cnt_r <= '0;
        end else begin
            if (body_push_s)      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (head_from_body_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({body_push_s, head_from_body_s})
                2'b10:   body_cnt_r <= body_cnt_r + (PTR_W+1)'(1);
                2'b01:   body_cnt_r <= body_cnt_r - (PTR_W+1)'(1);
                default: body_cnt_r <= body_cnt_r;
            endcase
        end
    end

    // FIFO body storage (payload only, no reset needed).
    always_ff @(posedge clk) begin
        if (body_push_s) body_r[wr_ptr_r] <= push_payload_s;
    end

    // Registered show-ahead head; an empty FIFO lets a fresh push bypass straight to the port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_r <= 1'b0; mem_addr_r <= '0; mem_data_r <= 32'd0; mem_strb_r <= 4'd0;
        end else if (head_from_body_s) begin
            mem_valid_r <= 1'b1;
            {mem_addr_r, mem_data_r, mem_strb_r} <= body_r[rd_ptr_r];
        end else if (head_from_push_s) begin
            mem_valid_r <= 1'b1;
            {mem_addr_r, mem_data_r, mem_strb_r} <= push_payload_s;
        end else if (pop_s) begin
            mem_valid_r <= 1'b0; mem_addr_r <= '0; mem_data_r <= 32'd0; mem_strb_r <= 4'd0;
        end
    end

    // Sticky completion flag; setting in DONE takes priority over clearing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 irq_r <= 1'b0;
        else if (state_r == ST_DONE) irq_r <= 1'b1;
        else if (irq_clear)          irq_r <= 1'b0;
    end

    assign in_ready      = in_ready_s;
    assign mem_valid     = mem_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_data      = mem_data_r;
    assign mem_strb      = mem_strb_r;
    assign busy          = (state_r == ST_RUN) || (state_r == ST_FLUSH);
    assign done          = (state_r == ST_DONE);
    assign interrupt     = irq_r;
    assign words_written = words_written_r;

endmodule
